// File: rtl/cycle_sequencer_if.sv
// Bus between the front-panel run control and the instruction-cycle sequencer.
// `SINGLE_STEP_EN adds the i_step request line.
interface cycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_stop;
  logic             i_halt;
  logic             i_need_write;
`ifdef SINGLE_STEP_EN
  logic             i_step;
`endif
  logic             o_running;
  logic             o_st_fetch;
  logic             o_st_decode;
  logic             o_st_exec;
  logic             o_st_write;
  logic             o_cdiv;
  logic             o_ncdiv;
  logic             o_instr_done;
  logic [CNT_W-1:0] o_instr_count;

`ifdef SINGLE_STEP_EN
  modport master (
    output i_start, i_stop, i_halt, i_need_write, i_step,
    input  o_running, o_st_fetch, o_st_decode, o_st_exec, o_st_write,
           o_cdiv, o_ncdiv, o_instr_done, o_instr_count
  );
  modport slave (
    input  i_start, i_stop, i_halt, i_need_write, i_step,
    output o_running, o_st_fetch, o_st_decode, o_st_exec, o_st_write,
           o_cdiv, o_ncdiv, o_instr_done, o_instr_count
  );
`else
  modport master (
    output i_start, i_stop, i_halt, i_need_write,
    input  o_running, o_st_fetch, o_st_decode, o_st_exec, o_st_write,
           o_cdiv, o_ncdiv, o_instr_done, o_instr_count
  );
  modport slave (
    input  i_start, i_stop, i_halt, i_need_write,
    output o_running, o_st_fetch, o_st_decode, o_st_exec, o_st_write,
           o_cdiv, o_ncdiv, o_instr_done, o_instr_count
  );
`endif
endinterface

// File: rtl/cycle_sequencer.sv
// Instruction-cycle sequencer: HALT/FETCH/DECODE/EXEC/WRITE with stretched memory states.
// Optional `SINGLE_STEP_EN: a rising edge on i_step in HALT runs exactly one instruction.
module cycle_sequencer #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  cycle_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WRITE
  } state_t;

  localparam logic [3:0] LP_WAIT    = 4'(WAIT_CYCLES);
  localparam logic       LP_STRETCH = (WAIT_CYCLES > 0);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_wait;
  logic             r_startPrev;
  logic             r_stopPend;
  logic             r_haltSeen;
  logic             r_running;
  logic             r_fetch;
  logic             r_decode;
  logic             r_exec;
  logic             r_write;
  logic             r_cdiv;
  logic [CNT_W-1:0] r_count;

  logic w_startEdge;
  logic w_stepEdge;
  logic w_stepHold;
  logic w_launch;
  logic w_done;
  logic w_endHalt;

  assign w_startEdge = bus.i_start & ~r_startPrev;

`ifdef SINGLE_STEP_EN
  logic r_stepPrev;
  logic r_stepMode;

  assign w_stepEdge = bus.i_step & ~r_stepPrev;
  assign w_stepHold = r_stepMode;

  // A step-launched instruction forces HALT at its end; a start edge in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stepPrev <= 1'b1;
      r_stepMode <= 1'b0;
    end else begin
      r_stepPrev <= bus.i_step;
      if (r_state == S_HALT && w_launch) begin
        r_stepMode <= ~w_startEdge;
      end else if (w_done) begin
        r_stepMode <= 1'b0;
      end
    end
  end
`else
  assign w_stepEdge = 1'b0;
  assign w_stepHold = 1'b0;
`endif

  assign w_launch  = (w_startEdge | w_stepEdge) & ~bus.i_stop;
  assign w_done    = (r_state == S_EXEC  && !bus.i_need_write) ||
                     (r_state == S_WRITE && r_wait == 4'd0);
  assign w_endHalt = r_stopPend | r_haltSeen | bus.i_stop | w_stepHold;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HALT:   if (w_launch) w_next = S_FETCH;
      S_FETCH:  if (r_wait == 4'd0) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (bus.i_need_write) w_next = S_WRITE;
        else                  w_next = w_endHalt ? S_HALT : S_FETCH;
      end
      S_WRITE:  if (r_wait == 4'd0) w_next = w_endHalt ? S_HALT : S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end

  // Strobes and cdiv are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_HALT;
      r_wait      <= 4'd0;
      r_startPrev <= 1'b1;
      r_stopPend  <= 1'b0;
      r_haltSeen  <= 1'b0;
      r_running   <= 1'b0;
      r_fetch     <= 1'b0;
      r_decode    <= 1'b0;
      r_exec      <= 1'b0;
      r_write     <= 1'b0;
      r_cdiv      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_startPrev <= bus.i_start;
      r_running   <= (w_next != S_HALT);
      r_fetch     <= (w_next == S_FETCH);
      r_decode    <= (w_next == S_DECODE);
      r_exec      <= (w_next == S_EXEC);
      r_write     <= (w_next == S_WRITE);
      r_cdiv      <= LP_STRETCH && (w_next == S_FETCH || w_next == S_WRITE);

      if (w_next != r_state && (w_next == S_FETCH || w_next == S_WRITE)) begin
        r_wait <= LP_WAIT;
      end else if (r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end

      if (w_done) begin
        r_count    <= r_count + CNT_W'(1);
        r_stopPend <= 1'b0;
        r_haltSeen <= 1'b0;
      end else begin
        if (bus.i_stop && r_state != S_HALT) r_stopPend <= 1'b1;
        if (r_state == S_DECODE)             r_haltSeen <= bus.i_halt;
      end
    end
  end

  assign bus.o_running     = r_running;
  assign bus.o_st_fetch    = r_fetch;
  assign bus.o_st_decode   = r_decode;
  assign bus.o_st_exec     = r_exec;
  assign bus.o_st_write    = r_write;
  assign bus.o_cdiv        = r_cdiv;
  assign bus.o_ncdiv       = ~r_cdiv;
  assign bus.o_instr_done  = w_done;
  assign bus.o_instr_count = r_count;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: three instances (WAIT 1/16-bit, WAIT 2/4-bit, WAIT 0/16-bit)
// share one stimulus stream and are checked against an instruction-position model.
module tb_cycle_sequencer;
  logic clk        = 1'b0;
  logic rst        = 1'b0;
  logic tStart     = 1'b0;
  logic tStop      = 1'b0;
  logic tHalt      = 1'b0;
  logic tNeedWrite = 1'b0;
  logic tStep      = 1'b0;
  int   nTests     = 0;
  int   nFail      = 0;

  always #5 clk = ~clk;

  logic [2:0]  oRun, oCdiv, oNcdiv, oDone;
  logic [3:0]  oSt  [3];
  logic [15:0] oCnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 0) ? 1 : (g == 1) ? 2 : 0;
    localparam int CW = (g == 1) ? 4 : 16;
    cycle_sequencer_if #(.CNT_W(CW)) bus ();
    assign bus.i_start      = tStart;
    assign bus.i_stop       = tStop;
    assign bus.i_halt       = tHalt;
    assign bus.i_need_write = tNeedWrite;
`ifdef SINGLE_STEP_EN
    assign bus.i_step       = tStep;
`endif
    cycle_sequencer #(.WAIT_CYCLES(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign oRun[g]   = bus.o_running;
    assign oCdiv[g]  = bus.o_cdiv;
    assign oNcdiv[g] = bus.o_ncdiv;
    assign oDone[g]  = bus.o_instr_done;
    assign oSt[g]    = {bus.o_st_fetch, bus.o_st_decode, bus.o_st_exec, bus.o_st_write};
    assign oCnt[g]   = 16'(bus.o_instr_count);
  end

  // Model: an instruction is a run of cycles numbered from 0; with W wait cycles,
  // 0..W fetch, W+1 decode, W+2 exec, W+3..2W+3 write.
  typedef struct {
    bit run;
    int pos;
    bit stopPend;
    bit haltSeen;
    bit prevStart;
    bit prevStep;
    bit stepMode;
    int count;
  } model_t;

  model_t m [3];

  function automatic int waitOf(int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 0;
  endfunction

  function automatic int maskOf(int i);
    return (i == 1) ? 32'h000F : 32'hFFFF;
  endfunction

  function automatic model_t modelReset();
    model_t n;
    n.run = 0; n.pos = 0; n.stopPend = 0; n.haltSeen = 0;
    n.prevStart = 1; n.prevStep = 1; n.stepMode = 0; n.count = 0;
    return n;
  endfunction

  function automatic logic [3:0] expSt(model_t x, int w);
    if (!x.run)         return 4'b0000;
    if (x.pos <= w)     return 4'b1000;
    if (x.pos == w + 1) return 4'b0100;
    if (x.pos == w + 2) return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic bit expDone(model_t x, int w, bit nw);
    return x.run && ((x.pos == w + 2 && !nw) || x.pos == 2 * w + 3);
  endfunction

  function automatic bit expCdiv(model_t x, int w);
    return x.run && (w > 0) && (x.pos <= w || x.pos >= w + 3);
  endfunction

  function automatic model_t modelNext(model_t x, int w, bit s, bit p, bit h, bit nw, bit st);
    model_t n;
    bit     sEdge;
    bit     stEdge;
    n      = x;
    sEdge  = s && !x.prevStart;
    stEdge = st && !x.prevStep;
    n.prevStart = s;
    n.prevStep  = st;
    if (!x.run) begin
      if ((sEdge || stEdge) && !p) begin
        n.run = 1; n.pos = 0; n.stepMode = !sEdge;
      end
    end else if (expDone(x, w, nw)) begin
      n.count    = x.count + 1;
      n.run      = !(x.stopPend || x.haltSeen || p || x.stepMode);
      n.pos      = 0;
      n.stopPend = 0; n.haltSeen = 0; n.stepMode = 0;
    end else begin
      n.pos = x.pos + 1;
      if (p) n.stopPend = 1;
      if (x.pos == w + 1) n.haltSeen = h;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m[i] <= modelReset();
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= modelNext(m[i], waitOf(i), tStart, tStop, tHalt, tNeedWrite, tStep);
    end
  end

  task automatic applyReset(input bit s);
    @(negedge clk);
    tStart = s; tStop = 0; tHalt = 0; tNeedWrite = 0; tStep = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Drives one cycle's inputs; outputs of that cycle are stable on return.
  task automatic applyStimulus(input bit s, input bit p, input bit h, input bit nw);
    @(negedge clk);
    tStart = s; tStop = p; tHalt = h; tNeedWrite = nw;
    #1;
  endtask

  task automatic test_reset();
    applyReset(1'b0);
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c < 8; c++) applyStimulus(1, 0, 0, 0);
    nTests++;
    if (oSt[0] !== 4'b0010) begin
      nFail++; $display("[TB] FAIL reset_pre_exec: got %b expected %b", oSt[0], 4'b0010);
    end
    nTests++;
    if (oCnt[0] !== 16'd1) begin
      nFail++; $display("[TB] FAIL reset_pre_count: got %0d expected 1", oCnt[0]);
    end
    #1 rst = 1'b1;
    #1;
    nTests++;
    if (oRun[0] !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_running: got %b expected 0", oRun[0]);
    end
    nTests++;
    if (oSt[0] !== 4'b0000) begin
      nFail++; $display("[TB] FAIL reset_states: got %b expected 0000", oSt[0]);
    end
    nTests++;
    if (oCdiv[0] !== 1'b0 || oNcdiv[0] !== 1'b1) begin
      nFail++; $display("[TB] FAIL reset_cdiv: got cdiv=%b ncdiv=%b expected 0/1", oCdiv[0], oNcdiv[0]);
    end
    nTests++;
    if (oDone[0] !== 1'b0) begin
      nFail++; $display("[TB] FAIL reset_done: got %b expected 0", oDone[0]);
    end
    nTests++;
    if (oCnt[0] !== 16'd0) begin
      nFail++; $display("[TB] FAIL reset_count: got %0d expected 0", oCnt[0]);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, 0, 0);
      nTests++;
      if (oRun !== 3'b000) begin
        nFail++; $display("[TB] FAIL reset_held_start: got %b expected 000", oRun);
      end
    end
  endtask

  task automatic test_single_instr();
    logic [3:0] stA [5] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b1000};
    logic [3:0] stC [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b1000, 4'b0100};
    bit cdA   [5] = '{1, 1, 0, 0, 1};
    bit doneA [5] = '{0, 0, 0, 1, 0};
    bit doneC [5] = '{0, 0, 1, 0, 0};
    int cntA  [5] = '{0, 0, 0, 0, 1};
    applyReset(1'b0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    nTests++;
    if (oRun[0] !== 1'b0) begin
      nFail++; $display("[TB] FAIL single_launch_cycle: got %b expected 0", oRun[0]);
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, 0, 0);
      nTests++;
      if (oSt[0] !== stA[c] || oSt[2] !== stC[c]) begin
        nFail++; $display("[TB] FAIL single_state c%0d: got %b/%b expected %b/%b", c, oSt[0], oSt[2], stA[c], stC[c]);
      end
      nTests++;
      if (oCdiv[0] !== cdA[c] || oNcdiv[0] !== !cdA[c] || oCdiv[2] !== 1'b0 || oNcdiv[2] !== 1'b1) begin
        nFail++; $display("[TB] FAIL single_cdiv c%0d: got %b%b/%b%b expected %b%b/01", c, oCdiv[0], oNcdiv[0], oCdiv[2], oNcdiv[2], cdA[c], !cdA[c]);
      end
      nTests++;
      if (oDone[0] !== doneA[c] || oDone[2] !== doneC[c]) begin
        nFail++; $display("[TB] FAIL single_done c%0d: got %b/%b expected %b/%b", c, oDone[0], oDone[2], doneA[c], doneC[c]);
      end
      nTests++;
      if (oCnt[0] !== 16'(cntA[c])) begin
        nFail++; $display("[TB] FAIL single_count c%0d: got %0d expected %0d", c, oCnt[0], cntA[c]);
      end
    end
  endtask

  task automatic test_write_wait2();
    logic [3:0] es;
    applyReset(1'b0);
    applyStimulus(1, 0, 0, 1);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1, 0, 0, 1);
      es = (c < 3) ? 4'b1000 : (c == 3) ? 4'b0100 : (c == 4) ? 4'b0010 : (c <= 7) ? 4'b0001 : 4'b1000;
      nTests++;
      if (oSt[1] !== es) begin
        nFail++; $display("[TB] FAIL write_state c%0d: got %b expected %b", c, oSt[1], es);
      end
      nTests++;
      if (oCdiv[1] !== (es[3] | es[0])) begin
        nFail++; $display("[TB] FAIL write_cdiv c%0d: got %b expected %b", c, oCdiv[1], es[3] | es[0]);
      end
      nTests++;
      if (oDone[1] !== (c == 7)) begin
        nFail++; $display("[TB] FAIL write_done c%0d: got %b expected %b", c, oDone[1], c == 7);
      end
    end
    nTests++;
    if (oCnt[1] !== 16'd1) begin
      nFail++; $display("[TB] FAIL write_count: got %0d expected 1", oCnt[1]);
    end
  endtask

  task automatic test_stop_mid();
    applyReset(1'b0);
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1, c == 8, 0, 0);
      nTests++;
      if (oRun[0] !== (c <= 11)) begin
        nFail++; $display("[TB] FAIL stop_running c%0d: got %b expected %b", c, oRun[0], c <= 11);
      end
      nTests++;
      if (oDone[0] !== (c % 4 == 3 && c <= 11)) begin
        nFail++; $display("[TB] FAIL stop_done c%0d: got %b expected %b", c, oDone[0], c % 4 == 3 && c <= 11);
      end
    end
    nTests++;
    if (oCnt[0] !== 16'd3) begin
      nFail++; $display("[TB] FAIL stop_count: got %0d expected 3", oCnt[0]);
    end
  endtask

  task automatic test_start_stop_same();
    applyReset(1'b0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 0, 0);
      nTests++;
      if (oRun[0] !== 1'b0) begin
        nFail++; $display("[TB] FAIL startstop_running c%0d: got %b expected 0", c, oRun[0]);
      end
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 0, c == 2, 0);
      nTests++;
      if (oRun[0] !== (c <= 3)) begin
        nFail++; $display("[TB] FAIL halt_running c%0d: got %b expected %b", c, oRun[0], c <= 3);
      end
    end
    nTests++;
    if (oCnt[0] !== 16'd1) begin
      nFail++; $display("[TB] FAIL halt_count: got %0d expected 1", oCnt[0]);
    end
  endtask

  task automatic test_wrap();
    int pulses  = 0;
    bit seen16  = 0;
    applyReset(1'b0);
    applyStimulus(1, 0, 0, 0);
    for (int c = 0; c < 200 && pulses < 17; c++) begin
      applyStimulus(1, 0, 0, 0);
      if (pulses == 16 && !seen16) begin
        seen16 = 1;
        nTests++;
        if (oCnt[1] !== 16'd0) begin
          nFail++; $display("[TB] FAIL wrap_zero: got %0d expected 0", oCnt[1]);
        end
      end
      if (oDone[1] === 1'b1) pulses++;
    end
    nTests++;
    if (pulses != 17) begin
      nFail++; $display("[TB] FAIL wrap_pulses: got %0d expected 17 within budget", pulses);
    end
    applyStimulus(1, 0, 0, 0);
    nTests++;
    if (oCnt[1] !== 16'd1) begin
      nFail++; $display("[TB] FAIL wrap_count: got %0d expected 1", oCnt[1]);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_step();
    applyReset(1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      tStep = 1'b1;
      applyStimulus(0, 0, 0, 0);
      tStep = 1'b0;
      nTests++;
      if (oRun[0] !== 1'b1) begin
        nFail++; $display("[TB] FAIL step_launch k%0d: got %b expected 1", k, oRun[0]);
      end
      for (int c = 0; c < 7; c++) applyStimulus(0, 0, 0, 0);
      nTests++;
      if (oRun[0] !== 1'b0) begin
        nFail++; $display("[TB] FAIL step_halted k%0d: got %b expected 0", k, oRun[0]);
      end
      nTests++;
      if (oCnt[0] !== 16'(k + 1)) begin
        nFail++; $display("[TB] FAIL step_count k%0d: got %0d expected %0d", k, oCnt[0], k + 1);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit s = 0;
    bit p, h, nw;
    int w;
    applyReset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) s = !s;
      p  = ($urandom_range(19) == 0);
      h  = ($urandom_range(5) == 0);
      nw = $urandom_range(1) != 0;
`ifdef SINGLE_STEP_EN
      if ($urandom_range(9) == 0) tStep = !tStep;
`endif
      applyStimulus(s, p, h, nw);
      for (int i = 0; i < 3; i++) begin
        w = waitOf(i);
        nTests++;
        if (oRun[i] !== m[i].run) begin
          nFail++; $display("[TB] FAIL rand_running[%0d] c%0d: got %b expected %b", i, c, oRun[i], m[i].run);
        end
        nTests++;
        if (oSt[i] !== expSt(m[i], w)) begin
          nFail++; $display("[TB] FAIL rand_state[%0d] c%0d: got %b expected %b", i, c, oSt[i], expSt(m[i], w));
        end
        nTests++;
        if (oCdiv[i] !== expCdiv(m[i], w) || oNcdiv[i] !== !expCdiv(m[i], w)) begin
          nFail++; $display("[TB] FAIL rand_cdiv[%0d] c%0d: got %b%b expected cdiv %b", i, c, oCdiv[i], oNcdiv[i], expCdiv(m[i], w));
        end
        nTests++;
        if (oDone[i] !== expDone(m[i], w, nw)) begin
          nFail++; $display("[TB] FAIL rand_done[%0d] c%0d: got %b expected %b", i, c, oDone[i], expDone(m[i], w, nw));
        end
        nTests++;
        if (oCnt[i] !== 16'(m[i].count & maskOf(i))) begin
          nFail++; $display("[TB] FAIL rand_count[%0d] c%0d: got %0d expected %0d", i, c, oCnt[i], m[i].count & maskOf(i));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_instr();
    test_write_wait2();
    test_stop_mid();
    test_start_stop_same();
    test_wrap();
`ifdef SINGLE_STEP_EN
    test_step();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
